// File: rtl/ipml_sync_fifo_v2.sv
// ipml_sync_fifo_v2: single-clock FIFO with standard or FWFT read mode, level count and almost flags.
// Sticky overflow/underflow flags are built only when IPML_SYNC_FIFO_ERR_FLAG_EN is defined.
module ipml_sync_fifo_v2 #(
   parameter int c_DATA_WIDTH       = 32,
   parameter int c_DEPTH_WIDTH      = 9,
   parameter int c_FWFT             = 0,
   parameter int c_ALMOST_FULL_NUM  = (1 << c_DEPTH_WIDTH) - 4,
   parameter int c_ALMOST_EMPTY_NUM = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [c_DATA_WIDTH-1:0]  wr_data,
   input  logic                     wr_en,
   output logic                     wr_full,
   output logic                     almost_full,
   input  logic                     rd_en,
   output logic [c_DATA_WIDTH-1:0]  rd_data,
   output logic                     rd_empty,
   output logic                     almost_empty,
   output logic [c_DEPTH_WIDTH:0]   water_level,
   output logic                     overflow,
   output logic                     underflow
);
   localparam int cap = 1 << c_DEPTH_WIDTH;
   localparam logic [c_DEPTH_WIDTH:0] cap_l = cap[c_DEPTH_WIDTH:0];
   localparam logic [c_DEPTH_WIDTH:0] af_l = c_ALMOST_FULL_NUM[c_DEPTH_WIDTH:0];
   localparam logic [c_DEPTH_WIDTH:0] ae_l = c_ALMOST_EMPTY_NUM[c_DEPTH_WIDTH:0];
   localparam logic [c_DEPTH_WIDTH:0] one_l = {{c_DEPTH_WIDTH{1'b0}}, 1'b1};
   localparam bit fwft = c_FWFT != 0;
   logic [c_DATA_WIDTH-1:0] mem [cap];
   logic [c_DEPTH_WIDTH:0] wr_ptr, rd_ptr, level;
   logic wr_acc, rd_acc, bypass, ram_wr, ram_rd;
   assign water_level  = level;
   assign wr_full      = level == cap_l;
   assign rd_empty     = level == '0;
   assign almost_full  = level >= af_l;
   assign almost_empty = level <= ae_l;
   assign wr_acc       = wr_en & ~wr_full;
   assign rd_acc       = rd_en & ~rd_empty;
   // FWFT: the output register holds the head word, so the RAM is skipped when it would be the head
   assign bypass = fwft && wr_acc && (rd_empty || (level == one_l && rd_acc));
   assign ram_wr = wr_acc & ~bypass;
   assign ram_rd = rd_acc & (!fwft || level != one_l);
   always_ff @(posedge clk)
      if (ram_wr) mem[wr_ptr[c_DEPTH_WIDTH-1:0]] <= wr_data;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         rd_data <= '0;
      end else begin
         if (ram_wr) wr_ptr <= wr_ptr + one_l;
         if (ram_rd) rd_ptr <= rd_ptr + one_l;
         level <= level + {{c_DEPTH_WIDTH{1'b0}}, wr_acc} - {{c_DEPTH_WIDTH{1'b0}}, rd_acc};
         if (bypass) rd_data <= wr_data;
         else if (ram_rd) rd_data <= mem[rd_ptr[c_DEPTH_WIDTH-1:0]];
      end
`ifdef IPML_SYNC_FIFO_ERR_FLAG_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en & wr_full) overflow <= 1'b1;
         if (rd_en & rd_empty) underflow <= 1'b1;
      end
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_ipml_sync_fifo_v2.sv
// tb_ipml_sync_fifo_v2: directed bench for a standard-mode and an FWFT-mode FIFO of depth 16.
module tb_ipml_sync_fifo_v2;
   logic clk = 1'b0, rst = 1'b1;
   logic [7:0] s_wd = '0, f_wd = '0, s_rd, f_rd;
   logic s_we = 1'b0, s_re = 1'b0, f_we = 1'b0, f_re = 1'b0;
   logic s_full, s_af, s_empty, s_ae, s_ovf, s_udf;
   logic f_full, f_af, f_empty, f_ae, f_ovf, f_udf;
   logic [4:0] s_lvl, f_lvl;
   int total = 0, bad = 0;
`ifdef IPML_SYNC_FIFO_ERR_FLAG_EN
   localparam bit err = 1'b1;
`else
   localparam bit err = 1'b0;
`endif

   always #5 clk = ~clk;

   ipml_sync_fifo_v2 #(.c_DATA_WIDTH(8), .c_DEPTH_WIDTH(4), .c_FWFT(0),
      .c_ALMOST_FULL_NUM(12), .c_ALMOST_EMPTY_NUM(4)) u_std (
      .clk(clk), .rst(rst), .wr_data(s_wd), .wr_en(s_we), .wr_full(s_full),
      .almost_full(s_af), .rd_en(s_re), .rd_data(s_rd), .rd_empty(s_empty),
      .almost_empty(s_ae), .water_level(s_lvl), .overflow(s_ovf), .underflow(s_udf));

   ipml_sync_fifo_v2 #(.c_DATA_WIDTH(8), .c_DEPTH_WIDTH(4), .c_FWFT(1),
      .c_ALMOST_FULL_NUM(12), .c_ALMOST_EMPTY_NUM(4)) u_fwft (
      .clk(clk), .rst(rst), .wr_data(f_wd), .wr_en(f_we), .wr_full(f_full),
      .almost_full(f_af), .rd_en(f_re), .rd_data(f_rd), .rd_empty(f_empty),
      .almost_empty(f_ae), .water_level(f_lvl), .overflow(f_ovf), .underflow(f_udf));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] q[$];
      int sent, got, cyc;
      // reset state
      tick; tick;
      chk("rst_s_empty", s_empty, 1); chk("rst_s_full", s_full, 0);
      chk("rst_s_ae", s_ae, 1); chk("rst_s_af", s_af, 0);
      chk("rst_s_lvl", s_lvl, 0); chk("rst_s_rd", s_rd, 0);
      chk("rst_s_ovf", s_ovf, 0); chk("rst_s_udf", s_udf, 0);
      chk("rst_f_empty", f_empty, 1); chk("rst_f_rd", f_rd, 0);
      rst = 1'b0;
      // standard: fill 16 words
      s_we = 1'b1;
      for (int i = 0; i < 16; i++) begin
         s_wd = 8'(i);
         tick;
         chk("s_fill_lvl", s_lvl, i + 1);
         chk("s_fill_empty", s_empty, 0);
         chk("s_fill_af", s_af, i >= 11);
         chk("s_fill_full", s_full, i == 15);
      end
      s_wd = 8'hFF;
      tick;
      chk("s_drop_lvl", s_lvl, 16);
      chk("s_drop_full", s_full, 1);
      chk("s_ovf_after_drop", s_ovf, err);
      s_we = 1'b0;
      // standard: drain 16 words
      s_re = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick;
         chk("s_drain_data", s_rd, i);
         chk("s_drain_lvl", s_lvl, 15 - i);
         chk("s_drain_ae", s_ae, (15 - i) <= 4);
         chk("s_drain_empty", s_empty, i == 15);
      end
      tick;
      chk("s_empty_read_hold", s_rd, 8'h0F);
      chk("s_empty_read_lvl", s_lvl, 0);
      chk("s_udf", s_udf, err);
      s_re = 1'b0;
      // standard: simultaneous write/read at level 8
      s_we = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s_wd = 8'(8'h20 + i);
         tick;
      end
      s_wd = 8'h28; s_re = 1'b1;
      tick;
      chk("s_both_lvl", s_lvl, 8);
      chk("s_both_data", s_rd, 8'h20);
      s_we = 1'b0;
      for (int i = 1; i < 9; i++) begin
         tick;
         chk("s_both_drain", s_rd, 8'h20 + i);
      end
      chk("s_both_empty", s_empty, 1);
      s_re = 1'b0;
      // standard: write at full with read
      s_we = 1'b1;
      for (int i = 0; i < 16; i++) begin
         s_wd = 8'(8'h30 + i);
         tick;
      end
      s_wd = 8'hEE; s_re = 1'b1;
      tick;
      chk("s_fullrw_lvl", s_lvl, 15);
      chk("s_fullrw_data", s_rd, 8'h30);
      s_we = 1'b0;
      for (int i = 1; i < 16; i++) begin
         tick;
         chk("s_fullrw_drain", s_rd, 8'h30 + i);
      end
      chk("s_fullrw_empty", s_empty, 1);
      chk("s_fullrw_lvl0", s_lvl, 0);
      s_re = 1'b0;
      // FWFT: single word appears without rd_en
      f_wd = 8'hA5; f_we = 1'b1;
      tick;
      f_we = 1'b0;
      chk("f_a5_empty", f_empty, 0);
      chk("f_a5_data", f_rd, 8'hA5);
      chk("f_a5_lvl", f_lvl, 1);
      tick;
      chk("f_a5_hold", f_rd, 8'hA5);
      f_re = 1'b1;
      tick;
      f_re = 1'b0;
      chk("f_a5_read_empty", f_empty, 1);
      chk("f_a5_read_lvl", f_lvl, 0);
      // FWFT: simultaneous write/read at level 1
      f_wd = 8'h11; f_we = 1'b1;
      tick;
      f_wd = 8'h22; f_re = 1'b1;
      tick;
      chk("f_both_data", f_rd, 8'h22);
      chk("f_both_empty", f_empty, 0);
      chk("f_both_lvl", f_lvl, 1);
      f_wd = 8'h33; f_re = 1'b0;
      tick;
      f_we = 1'b0; f_re = 1'b1;
      chk("f_two_head", f_rd, 8'h22);
      tick;
      chk("f_two_next", f_rd, 8'h33);
      chk("f_two_lvl", f_lvl, 1);
      tick;
      f_re = 1'b0;
      chk("f_two_empty", f_empty, 1);
      // FWFT: stream 40 words with random gaps
      sent = 0; got = 0; cyc = 0;
      while (got < 40 && cyc < 2000) begin
         f_we = (sent < 40) && ($urandom_range(0, 2) != 0);
         f_re = $urandom_range(0, 2) != 0;
         f_wd = 8'(8'h40 + sent);
         if (f_re && !f_empty) begin
            chk("stream_data", f_rd, q.pop_front());
            got++;
         end
         if (f_we && !f_full) begin
            q.push_back(f_wd);
            sent++;
         end
         tick;
         cyc++;
         chk("stream_lvl", f_lvl, q.size());
         chk("stream_empty", f_empty, q.size() == 0);
         chk("stream_full", f_full, q.size() == 16);
      end
      chk("stream_count", got, 40);
      f_re = 1'b0;
      // mid-stream async reset
      f_we = 1'b1; s_we = 1'b1;
      for (int i = 0; i < 5; i++) begin
         f_wd = 8'(8'h70 + i); s_wd = 8'(8'h70 + i);
         tick;
      end
      f_we = 1'b0; s_we = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_s_empty", s_empty, 1); chk("mid_rst_s_lvl", s_lvl, 0);
      chk("mid_rst_s_ae", s_ae, 1); chk("mid_rst_s_rd", s_rd, 0);
      chk("mid_rst_s_ovf", s_ovf, 0); chk("mid_rst_s_udf", s_udf, 0);
      chk("mid_rst_f_empty", f_empty, 1); chk("mid_rst_f_lvl", f_lvl, 0);
      chk("mid_rst_f_rd", f_rd, 0); chk("mid_rst_f_af", f_af, 0);
      #1 rst = 1'b0;
      f_wd = 8'h5A; s_wd = 8'h5A; f_we = 1'b1; s_we = 1'b1;
      tick;
      f_we = 1'b0; s_we = 1'b0;
      chk("post_rst_f_data", f_rd, 8'h5A);
      chk("post_rst_f_lvl", f_lvl, 1);
      s_re = 1'b1;
      tick;
      s_re = 1'b0;
      chk("post_rst_s_data", s_rd, 8'h5A);
      chk("post_rst_s_empty", s_empty, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
